// File: rtl/collision_ctl.sv
// Pointer/obstacle collision detector and lives/invulnerability controller.
// Stage 1 registers the pixel overlap test; stage 2 is the game FSM.
module collision_ctl #(
  parameter int POINTER_W     = 16,
  parameter int POINTER_H     = 16,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        game_on,
  input  logic        frame_tick,
  input  logic        restart,
  output logic        hit,
  output logic [2:0]  lives,
  output logic        invuln,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    INVULN,
    OVER
  } state_t;

  state_t      state_q, state_d;
  logic        raw_hit_q, raw_hit_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        invuln_q, invuln_d;
  logic        over_q, over_d;
  logic        take_hit;
  logic [12:0] x_hi, y_hi;

  // 13-bit bounds so a pointer at the right/bottom edge never wraps to 0
  assign x_hi = {1'b0, mouse_xpos} + 13'(POINTER_W - 1);
  assign y_hi = {1'b0, mouse_ypos} + 13'(POINTER_H - 1);

  assign raw_hit_d = ((obstacle_x != 12'd0) || (obstacle_y != 12'd0))
                  && (obstacle_x >= mouse_xpos)
                  && ({1'b0, obstacle_x} <= x_hi)
                  && (obstacle_y >= mouse_ypos)
                  && ({1'b0, obstacle_y} <= y_hi);

  always_ff @(posedge pclk) begin
    if (rst) raw_hit_q <= 1'b0;
    else     raw_hit_q <= raw_hit_d;
  end

  assign take_hit = (state_q == ARMED) && game_on
                 && raw_hit_q && !restart;

  always_ff @(posedge pclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = IDLE;
      lives_d = 3'(LIVES);
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (game_on) state_d = ARMED;
        end
        ARMED: begin
          if (!game_on) begin
            state_d = IDLE;
          end else if (take_hit) begin
            lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
            if (lives_d == 3'd0) begin
              state_d = OVER;
            end else begin
              state_d = INVULN;
              cnt_d   = 8'(INVULN_FRAMES);
            end
          end
        end
        INVULN: begin
          if (!game_on) begin
            state_d = IDLE;
          end else if (frame_tick) begin
            cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
            if (cnt_q <= 8'd1) state_d = ARMED;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit_d    = take_hit;
    invuln_d = (state_d == INVULN);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      lives_q  <= 3'(LIVES);
      cnt_q    <= 8'd0;
      hit_q    <= 1'b0;
      invuln_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      invuln_q <= invuln_d;
      over_q   <= over_d;
    end
  end

  assign hit       = hit_q;
  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_collision_ctl.sv
// Bench for collision_ctl: directed vector table, hand sequences,
// and randomized traffic against a rule-level reference model.
module tb_collision_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] obstacle_x = '0, obstacle_y = '0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic        game_on = 1'b0, frame_tick = 1'b0, restart = 1'b0;
  logic        hit, invuln, game_over;
  logic [2:0]  lives;

  collision_ctl dut (
    .pclk(pclk), .rst(rst),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .game_on(game_on), .frame_tick(frame_tick), .restart(restart),
    .hit(hit), .lives(lives), .invuln(invuln), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  int passed = 0;
  int total = 0;

  // reference model: 0 idle, 1 armed, 2 invulnerable, 3 over
  int m_mode = 0, m_lives = 3, m_frames = 0, m_hit = 0;
  int m_overlap_prev = 0;

  function automatic int overlap(int ox, int oy, int mx, int my);
    if (ox == 0 && oy == 0) return 0;
    return (ox >= mx && ox <= mx + 15 && oy >= my && oy <= my + 15)
           ? 1 : 0;
  endfunction

  task automatic model_edge();
    int ov;
    ov = overlap(int'(obstacle_x), int'(obstacle_y),
                 int'(mouse_xpos), int'(mouse_ypos));
    m_hit = 0;
    if (rst) begin
      m_mode = 0; m_lives = 3; m_frames = 0; ov = 0;
    end else if (restart) begin
      m_mode = 0; m_lives = 3; m_frames = 0;
    end else if (m_mode == 1) begin
      if (!game_on) m_mode = 0;
      else if (m_overlap_prev == 1) begin
        m_hit = 1;
        if (m_lives > 0) m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = 3;
        else begin m_mode = 2; m_frames = 60; end
      end
    end else if (m_mode == 2) begin
      if (!game_on) m_mode = 0;
      else if (frame_tick) begin
        m_frames = m_frames - 1;
        if (m_frames <= 0) begin m_mode = 1; m_frames = 0; end
      end
    end else if (m_mode == 0) begin
      if (game_on) m_mode = 1;
    end
    m_overlap_prev = ov;
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic chk4(string nm, int eh, int el, int ei, int eo);
    chk({nm, ".hit"}, int'(hit), eh);
    chk({nm, ".lives"}, int'(lives), el);
    chk({nm, ".invuln"}, int'(invuln), ei);
    chk({nm, ".game_over"}, int'(game_over), eo);
  endtask

  task automatic do_rst();
    rst = 1'b1; restart = 1'b0; game_on = 1'b0; frame_tick = 1'b0;
    obstacle_x = '0; obstacle_y = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic ticks(int n, string nm);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      chk(nm, int'(hit), 0);
      frame_tick = 1'b0; step();
      chk(nm, int'(hit), 0);
    end
  endtask

  typedef struct {
    logic rst, on, restart;
    int   ox, oy, mx, my;
    int   eh, el, ei, eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic on, logic rs,
                              int ox, int oy, int mx, int my,
                              int eh, int el, int ei, int eo);
    vec_t v;
    v.rst = r; v.on = on; v.restart = rs;
    v.ox = ox; v.oy = oy; v.mx = mx; v.my = my;
    v.eh = eh; v.el = el; v.ei = ei; v.eo = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    // first hit: 2-edge latency, lives 3->2, invulnerable
    add(1, 0, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0, 108, 110, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 1, 2, 1, 0);
    add(0, 1, 0,   0,   0, 100, 100, 0, 2, 1, 0);
    // game_on falls with a pending overlap
    add(1, 0, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0, 100, 100, 100, 100, 0, 3, 0, 0);
    add(0, 0, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 0, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    // far corner hit without wrap
    add(0, 1, 0, 4095, 4095, 4090, 4090, 0, 3, 0, 0);
    add(0, 1, 0,    0,    0, 4090, 4090, 1, 2, 1, 0);
    add(1, 0, 0,    0,    0, 4090, 4090, 0, 3, 0, 0);
    add(0, 1, 0,    0,    0, 4090, 4090, 0, 3, 0, 0);
    add(0, 1, 0,   10,   10, 4090, 4090, 0, 3, 0, 0);
    add(0, 1, 0,    0,    0, 4090, 4090, 0, 3, 0, 0);
    add(0, 1, 0,    0,    0,    0,    0, 0, 3, 0, 0);
    add(0, 1, 0,    0,    0,    0,    0, 0, 3, 0, 0);
    // box edges: x=mx+16 misses, (mx+15,my+15) hits
    add(0, 1, 0, 116, 105, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0, 115, 115, 100, 100, 0, 3, 0, 0);
    add(0, 1, 0,   0,   0, 100, 100, 1, 2, 1, 0);
    add(0, 0, 1,   0,   0, 100, 100, 0, 3, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; game_on = tbl[i].on; restart = tbl[i].restart;
      obstacle_x = 12'(tbl[i].ox); obstacle_y = 12'(tbl[i].oy);
      mouse_xpos = 12'(tbl[i].mx); mouse_ypos = 12'(tbl[i].my);
      frame_tick = 1'b0;
      step();
      chk4($sformatf("vec%0d", i), tbl[i].eh, tbl[i].el,
           tbl[i].ei, tbl[i].eo);
    end
    restart = 1'b0;

    // continuous overlap through the invulnerability window
    do_rst();
    mouse_xpos = 12'd100; mouse_ypos = 12'd100;
    game_on = 1'b1; step();
    obstacle_x = 12'd108; obstacle_y = 12'd110;
    step(); step();
    chk4("sc2_hit1", 1, 2, 1, 0);
    ticks(59, "sc2_quiet");
    chk("sc2_still_inv", int'(invuln), 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk4("sc2_tick60", 0, 2, 0, 0);
    step();
    chk4("sc2_hit2", 1, 1, 1, 0);

    // last life, then game over and restart
    ticks(59, "sc4_quiet");
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    chk4("sc4_hit3", 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      frame_tick = (i == 2); step();
      chk4("sc4_over", 0, 0, 0, 1);
    end
    frame_tick = 1'b0;
    game_on = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    chk4("sc4_restart", 0, 3, 0, 0);
    step(); step();
    chk4("sc4_idle", 0, 3, 0, 0);

    // reset in the middle of the invulnerability window
    do_rst();
    game_on = 1'b1; step();
    obstacle_x = 12'd108; obstacle_y = 12'd110;
    step(); step();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    ticks(30, "sc6_quiet");
    chk4("sc6_inv30", 0, 2, 1, 0);
    rst = 1'b1; restart = 1'b1; step();
    chk4("sc6_rst", 0, 3, 0, 0);
    rst = 1'b0; restart = 1'b0;

    // randomized traffic against the model
    do_rst();
    for (int c = 0; c < 6000; c++) begin
      int t;
      rst = ($urandom_range(0, 499) == 0);
      restart = ($urandom_range(0, 399) == 0);
      game_on = ($urandom_range(0, 19) != 0);
      frame_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        mouse_xpos = 12'($urandom_range(4070, 4095));
        mouse_ypos = 12'($urandom_range(4070, 4095));
      end else begin
        mouse_xpos = 12'($urandom_range(0, 40));
        mouse_ypos = 12'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 3) == 0) begin
        obstacle_x = 12'd0; obstacle_y = 12'd0;
      end else begin
        t = int'(mouse_xpos) + int'($urandom_range(0, 40)) - 8;
        obstacle_x = 12'(t);
        t = int'(mouse_ypos) + int'($urandom_range(0, 40)) - 8;
        obstacle_y = 12'(t);
      end
      step();
      chk4("rand", m_hit, m_lives, (m_mode == 2) ? 1 : 0,
           (m_mode == 3) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/collision_ctl.md
COLLISION_CTL -- requirements
Module: collision_ctl

Interface
REQ-001 Parameter POINTER_W, default 16: pointer hit-box width in pixels.
REQ-002 Parameter POINTER_H, default 16: pointer hit-box height in pixels.
REQ-003 Parameter LIVES, default 3: lives at game start, range 1..7.
REQ-004 Parameter INVULN_FRAMES, default 60: frames of invulnerability after a hit, range 1..255.
REQ-005 Port pclk, input, 1: pixel clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous reset, active-high.
REQ-007 Port obstacle_x, input, 12: hcount of the obstacle pixel currently drawn; 0 means no pixel.
REQ-008 Port obstacle_y, input, 12: vcount of the obstacle pixel currently drawn; 0 means no pixel.
REQ-009 Port mouse_xpos, input, 12: pointer top-left x.
REQ-010 Port mouse_ypos, input, 12: pointer top-left y.
REQ-011 Port game_on, input, 1: high while an obstacle round runs.
REQ-012 Port frame_tick, input, 1: one-cycle pulse at frame start.
REQ-013 Port restart, input, 1: one-cycle pulse from the menu starting a new game.
REQ-014 Port hit, output, 1: one-cycle pulse per accepted collision.
REQ-015 Port lives, output, 3: lives remaining.
REQ-016 Port invuln, output, 1: high during the invulnerability window, used for pointer blinking.
REQ-017 Port game_over, output, 1: high once lives reach 0.

Function
REQ-018 Stage 1 shall register raw_hit = (obstacle_x!=0 || obstacle_y!=0) && obstacle_x in [mouse_xpos, mouse_xpos+POINTER_W-1] && obstacle_y in [mouse_ypos, mouse_ypos+POINTER_H-1].
REQ-019 The upper bounds shall be computed 13 bits wide, so no wrap occurs at mouse_xpos/ypos near 4095.
REQ-020 The FSM shall have four states: IDLE, ARMED, INVULN, OVER.
REQ-021 IDLE: go to ARMED when game_on=1; registered raw_hit is ignored.
REQ-022 ARMED: registered raw_hit=1 and game_on=1 -> pulse hit and decrement lives on the same edge.
REQ-023 ARMED, after a hit: if the new lives value is 0 -> OVER; otherwise -> INVULN and load frame counter with INVULN_FRAMES.
REQ-024 INVULN: raw_hit is ignored; each frame_tick decrements the counter; at counter 1 with frame_tick -> ARMED.
REQ-025 ARMED or INVULN with game_on=0 -> IDLE, with lives and counter held.
REQ-026 game_on=0 takes priority over a simultaneous raw_hit: no hit pulse and no decrement.
REQ-027 OVER: game_over=1 and hit=0; raw_hit and game_on are ignored.
REQ-028 restart in any state: lives=LIVES, counter=0, game_over=0, state IDLE, no hit pulse that cycle.
REQ-029 restart has priority over a simultaneous raw_hit.
REQ-030 Latency: coordinate sample at edge N gives hit high after edge N+2, for exactly one cycle.
REQ-031 invuln shall equal (state==INVULN), registered.
REQ-032 lives shall never underflow below 0.
REQ-033 At most one hit per cycle; a multi-pixel overlap in ARMED yields one hit, because the FSM leaves ARMED on the first hit.

Reset
REQ-034 rst shall force state=IDLE, lives=LIVES, counter=0, hit=0, invuln=0, game_over=0, and clear the stage-1 register.
REQ-035 rst mid-operation, including during INVULN or OVER, shall take effect on the next edge and override restart.

Verification
REQ-036 Scenario 1: mouse (100,100), game_on=1, obstacle (108,110) for 1 cycle -> hit pulse 2 cycles later, lives 3->2, invuln=1.
REQ-037 Scenario 2: after scenario 1, keep overlapping for 59 frame_ticks -> no further hit; on the 60th tick -> invuln=0; the next overlap -> lives=1.
REQ-038 Scenario 3: mouse (4090,4090), obstacle (4095,4095) -> hit; obstacle (10,10) -> no hit (no wrap); obstacle (0,0) with mouse (0,0) -> no hit.
REQ-039 Scenario 4: LIVES=3, three hits separated by the invulnerability window -> lives=0, game_over=1; a further overlap -> no hit; restart -> lives=3, game_over=0, IDLE.
REQ-040 Scenario 5: raw_hit in the same cycle game_on falls -> no hit, lives unchanged, state IDLE.
REQ-041 Scenario 6: rst asserted during INVULN with counter=30 -> next cycle all outputs at reset values, lives=3.
